// File: rtl/apple_generator_pkg.sv
// Shared constants for the apple generator and the field stage.
package apple_generator_pkg;

   // Two-bit cell encoding used across the playfield datapath
   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_SNAKE = 2'b01;
   localparam logic [1:0] CELL_APPLE = 2'b10;
   localparam logic [1:0] CELL_BLOCK = 2'b11;

   // Galois feedback taps for the 16-bit generator
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2,
      ST_FULL = 2'd3
   } state_t;

   // One right-shift Galois step
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/apple_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR, reloaded with SEED on reset.
module lfsr16
   import apple_generator_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] value
);

   // Advance every cycle regardless of what the consumer is doing
   always_ff @(posedge clk) begin
      if (rst) value <= SEED;
      else     value <= lfsr_next(value);
   end

endmodule

// File: rtl/apple_generator.sv
// Picks a uniformly random empty cell: one multiply, then a one-cell-per-cycle scan.
module apple_generator
   import apple_generator_pkg::*;
#(
   parameter int unsigned SIZE_X = 10,
   parameter int unsigned SIZE_Y = 10,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req,
   input  logic [2*SIZE_X*SIZE_Y-1:0] field,
   input  logic [15:0]                empty_cells,
   output logic [7:0]                 apple_x,
   output logic [7:0]                 apple_y,
   output logic                       apple_valid,
   output logic                       no_space,
   output logic                       busy
);

   localparam int unsigned NCELLS   = SIZE_X * SIZE_Y;
   localparam int unsigned FW       = 2 * NCELLS;
   localparam logic [15:0] LAST_IDX = 16'(NCELLS - 1);
   localparam logic [7:0]  X_LAST   = 8'(SIZE_X - 1);

   state_t          state;
   logic [FW-1:0]   snap;
   logic [15:0]     target;
   logic [15:0]     hits;
   logic [15:0]     idx;
   logic [7:0]      x_cnt;
   logic [7:0]      y_cnt;
   logic [15:0]     lfsr_value;
   logic            cell_empty_c;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .value (lfsr_value)
   );

   // The snapshot shifts down each cycle, so the current cell is always in bits [1:0]
   assign cell_empty_c = (snap[1:0] == CELL_EMPTY);

   // Request handling, scan counters and registered pulse outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         snap        <= '0;
         target      <= '0;
         hits        <= '0;
         idx         <= '0;
         x_cnt       <= '0;
         y_cnt       <= '0;
         apple_x     <= '0;
         apple_y     <= '0;
         apple_valid <= 1'b0;
         no_space    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  if (empty_cells == 16'd0) begin
                     no_space <= 1'b1;
                     state    <= ST_FULL;
                  end else begin
                     snap   <= field;
                     target <= 16'((32'(lfsr_value) * 32'(empty_cells)) >> 16);
                     hits   <= '0;
                     idx    <= '0;
                     x_cnt  <= '0;
                     y_cnt  <= '0;
                     busy   <= 1'b1;
                     state  <= ST_SCAN;
                  end
               end
            end
            ST_SCAN: begin
               if (cell_empty_c && (hits == target)) begin
                  apple_x     <= x_cnt;
                  apple_y     <= y_cnt;
                  apple_valid <= 1'b1;
                  busy        <= 1'b0;
                  state       <= ST_DONE;
               end else begin
                  if (cell_empty_c) hits <= hits + 16'd1;
                  if (idx == LAST_IDX) begin
                     // Field held fewer empty cells than empty_cells claimed
                     no_space <= 1'b1;
                     busy     <= 1'b0;
                     state    <= ST_FULL;
                  end else begin
                     snap <= snap >> 2;
                     idx  <= idx + 16'd1;
                     if (x_cnt == X_LAST) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + 8'd1;
                     end else begin
                        x_cnt <= x_cnt + 8'd1;
                     end
                  end
               end
            end
            ST_DONE: begin
               apple_valid <= 1'b0;
               state       <= ST_IDLE;
            end
            ST_FULL: begin
               no_space <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apple_generator.sv
// Self-checking bench for apple_generator: directed table, hand sequences, random vs. model.
module tb_apple_generator;
   import apple_generator_pkg::*;

   localparam int unsigned SX     = 10;
   localparam int unsigned SY     = 10;
   localparam int unsigned NCELLS = SX * SY;
   localparam int unsigned FW     = 2 * NCELLS;
   localparam logic [15:0] TSEED  = 16'h8000;

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic [FW-1:0] field;
   logic [15:0]   empty_cells;
   logic [7:0]    apple_x;
   logic [7:0]    apple_y;
   logic          apple_valid;
   logic          no_space;
   logic          busy;

   int vectors     = 0;
   int miscompares = 0;
   int last_x      = 0;
   int last_y      = 0;
   logic [15:0] lfsr_m;

   apple_generator #(.SIZE_X(SX), .SIZE_Y(SY), .SEED(TSEED)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .field       (field),
      .empty_cells (empty_cells),
      .apple_x     (apple_x),
      .apple_y     (apple_y),
      .apple_valid (apple_valid),
      .no_space    (no_space),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Reference generator: 16-bit Galois LFSR, taps 0xB400, reloaded on reset
   always @(posedge clk) begin
      if (rst) lfsr_m <= TSEED;
      else     lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [FW-1:0] fill(input logic [1:0] c);
      logic [FW-1:0] f;
      for (int n = 0; n < int'(NCELLS); n++) f[2*n +: 2] = c;
      return f;
   endfunction

   function automatic logic [FW-1:0] with_cell(input logic [FW-1:0] f, input int x, input int y,
                                               input logic [1:0] c);
      logic [FW-1:0] r;
      r = f;
      r[2*(y*int'(SX) + x) +: 2] = c;
      return r;
   endfunction

   // Expected outcome from the placement rule: pick the target-th empty cell in raster order
   task automatic model(input logic [FW-1:0] f, input logic [15:0] ec, input logic [15:0] lv,
                        output bit v, output int lat, output int x, output int y);
      longint tgt;
      int seen;
      v = 1'b0; lat = int'(NCELLS) + 1; x = last_x; y = last_y;
      if (ec == 16'd0) begin
         lat = 1;
      end else begin
         tgt  = (longint'(lv) * longint'(ec)) / 65536;
         seen = 0;
         for (int n = 0; n < int'(NCELLS); n++) begin
            if (!v && f[2*n +: 2] == CELL_EMPTY) begin
               if (longint'(seen) == tgt) begin
                  v = 1'b1; lat = n + 2; x = n % int'(SX); y = n / int'(SX);
               end
               seen++;
            end
         end
      end
   endtask

   // Issue one request and watch the outputs cycle by cycle for a bounded window
   task automatic run_req(input string name, input logic [FW-1:0] f, input logic [15:0] ec,
                          input bit ev, input int elat, input int ex, input int ey,
                          input bit disturb);
      int first = -1;
      int nv = 0, nn = 0, bad_busy = 0;
      int cx = -1, cy = -1;
      field = f; empty_cells = ec; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      for (int k = 1; k <= int'(NCELLS) + 4; k++) begin
         if (apple_valid) begin
            nv++;
            if (first < 0) begin first = k; cx = int'(apple_x); cy = int'(apple_y); end
         end
         if (no_space) begin
            nn++;
            if (first < 0) begin first = k; cx = int'(apple_x); cy = int'(apple_y); end
         end
         if (busy !== (k < elat)) bad_busy++;
         if (disturb) begin
            req   = (k < 30) && (k % 2 == 1);
            field = fill(CELL_EMPTY);
            empty_cells = 16'(NCELLS);
         end
         @(posedge clk); #1;
      end
      req = 1'b0;
      check({name, " valid_pulses"}, 32'(nv), ev ? 32'd1 : 32'd0);
      check({name, " nospace_pulses"}, 32'(nn), ev ? 32'd0 : 32'd1);
      check({name, " latency"}, 32'(first), 32'(elat));
      check({name, " apple_x"}, 32'(cx), 32'(ex));
      check({name, " apple_y"}, 32'(cy), 32'(ey));
      check({name, " busy_window"}, 32'(bad_busy), 32'd0);
      last_x = ex; last_y = ey;
   endtask

   typedef struct {
      logic [FW-1:0] f;
      logic [15:0]   ec;
      bit            ev;
      int            lat;
      int            ex;
      int            ey;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [FW-1:0] f;
      int            nempty;
      logic [15:0]   ec;
      bit            ev;
      int            elat, ex, ey, p;

      tbl[0] = '{fill(CELL_EMPTY), 16'd100, 1'b1, 52, 0, 5};
      tbl[1] = '{with_cell(fill(CELL_SNAKE), 7, 3, CELL_EMPTY), 16'd1, 1'b1, 39, 7, 3};
      tbl[2] = '{fill(CELL_EMPTY), 16'd0, 1'b0, 1, 7, 3};
      tbl[3] = '{fill(CELL_SNAKE), 16'd1, 1'b0, 101, 7, 3};
      tbl[4] = '{fill(CELL_EMPTY), 16'd1, 1'b1, 2, 0, 0};
      tbl[5] = '{with_cell(fill(CELL_BLOCK), 9, 9, CELL_EMPTY), 16'd1, 1'b1, 101, 9, 9};

      rst = 1'b1; req = 1'b0; field = '0; empty_cells = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset apple_x", 32'(apple_x), 32'd0);
      check("reset apple_y", 32'(apple_y), 32'd0);
      check("reset pulses", {30'd0, apple_valid, no_space}, 32'd0);
      check("reset busy", 32'(busy), 32'd0);

      // Directed table; entry 0 relies on the request landing in the first cycle after reset
      for (int i = 0; i < 6; i++)
         run_req($sformatf("tbl%0d", i), tbl[i].f, tbl[i].ec, tbl[i].ev, tbl[i].lat,
                 tbl[i].ex, tbl[i].ey, 1'b0);

      // req pulses and field changes during the scan must not affect the snapshot result
      run_req("disturb", with_cell(fill(CELL_SNAKE), 7, 3, CELL_EMPTY), 16'd1, 1'b1, 39, 7, 3, 1'b1);

      // Reset in the middle of a scan aborts silently
      begin
         int pulses = 0;
         field = fill(CELL_EMPTY); empty_cells = 16'd100; req = 1'b1;
         @(posedge clk); #1;
         req = 1'b0;
         for (int k = 1; k <= 10; k++) begin
            if (apple_valid || no_space) pulses++;
            if (k < 10) begin @(posedge clk); #1; end
         end
         check("midscan busy", 32'(busy), 32'd1);
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         check("abort apple_x", 32'(apple_x), 32'd0);
         check("abort apple_y", 32'(apple_y), 32'd0);
         check("abort busy", 32'(busy), 32'd0);
         check("abort pulses", 32'(pulses) + {30'd0, apple_valid, no_space}, 32'd0);
         last_x = 0; last_y = 0;
         run_req("after_reset", fill(CELL_EMPTY), 16'd100, 1'b1, 52, 0, 5, 1'b0);
      end

      // Random fields, with empty_cells occasionally inconsistent with the field
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(4))
            0:       p = 0;
            1:       p = 3;
            2:       p = 20;
            3:       p = 60;
            default: p = 97;
         endcase
         nempty = 0;
         for (int n = 0; n < int'(NCELLS); n++) begin
            if (int'($urandom_range(99)) < p) begin
               f[2*n +: 2] = CELL_EMPTY;
               nempty++;
            end else begin
               f[2*n +: 2] = 2'($urandom_range(2) + 1);
            end
         end
         case ($urandom_range(5))
            0:       ec = 16'(nempty + int'($urandom_range(5)) + 1);
            1:       ec = (nempty > 1) ? 16'($urandom_range(nempty - 1) + 1) : 16'(nempty);
            default: ec = 16'(nempty);
         endcase
         model(f, ec, lfsr_m, ev, elat, ex, ey);
         run_req($sformatf("rand%0d", i), f, ec, ev, elat, ex, ey, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/apple_generator.md
# apple_generator

Places a new apple on a uniformly chosen empty cell of the playfield. Sits directly downstream of the field/empty-cell calculation stage: it consumes the packed `field` vector and the `empty_cells` count, and returns the apple coordinates to the game controller, which writes the apple into the field. A request is served by one multiply followed by a one-cell-per-cycle scan, so the result is deterministic and bounded in time.

## Interface
- `SIZE_X`, 10, field width in cells (≤ 255)
- `SIZE_Y`, 10, field height in cells (≤ 255)
- `SEED`, 16'hACE1, LFSR reset value; must be non-zero

- `clk` in 1: clock
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `req` in 1: request a new apple. Sampled only in IDLE.
- `field` in 2·SIZE_X·SIZE_Y: packed cells. Cell (x,y) occupies bits [2n+1:2n], where n = y·SIZE_X + x. Encoding: 00 empty, 01 snake, 10 apple, 11 block.
- `empty_cells` in 16: number of 00 cells in `field`
- `apple_x` out 8: x coordinate of the placed apple
- `apple_y` out 8: y coordinate of the placed apple
- `apple_valid` out 1: one-cycle pulse; coordinates are valid from this cycle on
- `no_space` out 1: one-cycle pulse; the request could not be served
- `busy` out 1: high while in SCAN

## Operation
- **LFSR:** 16-bit Galois, taps 0xB400. It free-runs and advances every cycle, including while busy. It loads `SEED` on `rst`.
- **States:** IDLE, SCAN, DONE, FULL.
- **IDLE, `req`=1 and `empty_cells`=0:** go to FULL.
- **IDLE, `req`=1 and `empty_cells`≠0:**
  - Snapshot `field` into an internal register.
  - Compute target = (lfsr_current × `empty_cells`) >> 16. The product is 32 bits; target lies in [0, `empty_cells`−1].
  - Clear the hit counter and cell index, then go to SCAN.
- **SCAN:** one cell per cycle in increasing n. x and y are kept as separate counters, with x wrapping at SIZE_X−1 and y incrementing on each wrap.
  - Cell 00 and hit count = target: latch x/y into `apple_x`/`apple_y` and go to DONE.
  - Cell 00 and hit count ≠ target: increment the hit count.
  - Last cell (n = SIZE_X·SIZE_Y−1) with no match: go to FULL. This covers a `field`/`empty_cells` mismatch.
- **DONE:** `apple_valid`=1 for one cycle, then IDLE.
- **FULL:** `no_space`=1 for one cycle, then IDLE. `apple_x`/`apple_y` are unchanged.
- **Ignored inputs:**
  - `req` outside IDLE is ignored; it is not queued.
  - Changes to `field`/`empty_cells` during SCAN are ignored because the snapshot is used.
- **Reset:** `rst` has priority over everything, including a same-cycle `req`. Mid-scan reset aborts with no pulse.
- **Reset values:** state IDLE, `apple_x`=0, `apple_y`=0, `apple_valid`=0, `no_space`=0, `busy`=0, LFSR=`SEED`.

## Timing
- `req` is sampled in cycle t.
- SCAN runs from cycle t+1; cell n is examined in cycle t+1+n.
- Match on cell n → `apple_valid` is high in cycle t+2+n. Latency is n+2, maximum SIZE_X·SIZE_Y+1.
- `empty_cells`=0 → `no_space` is high in cycle t+1.
- Scan exhaustion → `no_space` is high in cycle t+1+SIZE_X·SIZE_Y.
- The earliest next accepted `req` is the cycle after the pulse, once back in IDLE.
- `busy` is high exactly during the SCAN cycles.

## Structure
- **Shared package:**
  - cell encoding constants CELL_EMPTY/SNAKE/APPLE/BLOCK, shared with the field stage
  - state encoding
  - LFSR tap constant
- **Sub-module `lfsr16`:** holds the free-running generator, with `SEED` parameter, `clk`, `rst`, and 16-bit `value` output.
- **Top level:** state machine, snapshot register, 16×16 multiplier, counters.

## Test plan
- **All cells empty, `SEED`=16'h8000:** `empty_cells`=100, `req` in the first cycle after reset → target 50 → `apple_x`=0, `apple_y`=5, `apple_valid` at t+52.
- **Single empty cell at (7,3), `empty_cells`=1:** target 0 for any LFSR value → `apple_x`=7, `apple_y`=3, `apple_valid` at t+39.
- **Empty or inconsistent field:**
  - `empty_cells`=0 → `no_space` at t+1, coordinates unchanged, no `apple_valid`.
  - `empty_cells`=1 but no 00 cell in `field` → `no_space` at t+101.
- **`req` pulses during SCAN, with `field` changed mid-scan:** ignored; the result matches the snapshot; exactly one `apple_valid`.
- **`rst` at t+10 of a scan:** next cycle IDLE, all outputs 0, no pulse. A `req` afterwards behaves as in the first scenario.
